ret_pred_queue: RTL and testbench
=================================

RET_PRED_QUEUE -- requirements
Module: ret_pred_queue

Interface
REQ-001 SHALL have parameter DEPTH_INDEX, default 2, queue depth = 2**DEPTH_INDEX entries.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port stall  input  1  pipeline stall; blocks enqueue and dequeue.
REQ-005 SHALL have port flush  input  1  pipeline flush; discards all queued predictions.
REQ-006 SHALL have port if_valid  input  1  fetch-stage instruction valid.
REQ-007 SHALL have port if_rdata  input  32  fetched instruction word.
REQ-008 SHALL have port ras_target  input  32  top-of-stack return address from the return address stack.
REQ-009 SHALL have port ras_empty  input  1  return address stack holds no entries.
REQ-010 SHALL have port ex_ret_valid  input  1  EX stage resolving a return-type jalr.
REQ-011 SHALL have port ex_target  input  32  actual jalr target computed in EX.
REQ-012 SHALL have port pred_taken  output  1  fetch redirect to pred_target this cycle.
REQ-013 SHALL have port pred_target  output  32  predicted return address.
REQ-014 SHALL have port fetch_stall  output  1  queue full; fetch must hold.
REQ-015 SHALL have port mispredict  output  1  registered; resolved return mispredicted.
REQ-016 SHALL have port correct_target  output  32  registered; redirect address when mispredict=1.
REQ-017 SHALL have port count  output  DEPTH_INDEX+1  current occupancy.

Function
REQ-018 SHALL decode a return as: opcode 7'b1100111, rs1 in {x1,x5}, rd == x0.
REQ-019 SHALL define enq_fire = if_valid & is_return & ~stall & ~flush & ~full.
REQ-020 SHALL drive pred_taken = enq_fire & ~ras_empty and pred_target = ras_target with bit 0 cleared, both combinational, zero latency.
REQ-021 SHALL, on enq_fire, write entry {pv = ~ras_empty, tgt = pred_target} at tail; pv=0 entries mean fall-through (not-taken) prediction.
REQ-022 SHALL drive fetch_stall = if_valid & is_return & full, combinational; no same-cycle bypass through a dequeue.
REQ-023 SHALL define deq_fire = ex_ret_valid & ~stall & ~flush & ~empty; on deq_fire pop head (strict FIFO order).
REQ-024 SHALL, on deq_fire, set mispredict next cycle to (~head.pv) | (head.tgt != {ex_target[31:1],1'b0}); correct_target next cycle = {ex_target[31:1],1'b0}.
REQ-025 SHALL, on ex_ret_valid & ~stall & ~flush with queue empty, assert mispredict next cycle with correct_target = {ex_target[31:1],1'b0}, leaving pointers unchanged.
REQ-026 SHALL hold mispredict high exactly one cycle per resolve; 0 in all other cycles; correct_target holds last value otherwise.
REQ-027 SHALL support simultaneous enq_fire and deq_fire: count unchanged, both pointers advance.
REQ-028 SHALL wrap head/tail pointers modulo 2**DEPTH_INDEX; full = (count == 2**DEPTH_INDEX), empty = (count == 0).
REQ-029 SHALL, on flush, set count=0 and head=tail=0 at next edge; flush overrides enqueue and dequeue in the same cycle; mispredict next cycle = 0.
REQ-030 SHALL ignore ex_ret_valid while stall=1 (no pop, no mispredict update).

Reset
REQ-031 SHALL, on rst at rising edge, set count=0, head=tail=0, mispredict=0, correct_target=32'h0; rst overrides flush, enqueue and dequeue.
REQ-032 SHALL, when rst asserts mid-operation, discard all queued entries; entry contents need not be cleared.

Verification
REQ-033 Return fetched, ras_target=32'h0000_1235, ras_empty=0 -> pred_taken=1, pred_target=32'h0000_1234 same cycle; count 0->1.
REQ-034 Resolve with ex_target=32'h0000_1234 after REQ-033 -> mispredict=0 next cycle, count 1->0.
REQ-035 Return fetched with ras_empty=1, later resolve ex_target=32'h0000_2000 -> pred_taken=0; mispredict=1, correct_target=32'h0000_2000 next cycle.
REQ-036 Four returns fetched (DEPTH_INDEX=2) without resolve, fifth presented -> count=4, fetch_stall=1, pred_taken=0; simultaneous resolve + fetch at full -> stall held that cycle.
REQ-037 Queue holds 3 entries, flush=1 together with ex_ret_valid=1 -> count=0 next cycle, mispredict=0.
REQ-038 rst asserted with count=2 and ex_ret_valid=1 -> count=0, mispredict=0, correct_target=32'h0 next cycle.

Source files
------------

// File: rtl/ret_pred_queue.sv
// Return-address prediction queue: predicts return targets at fetch from the RAS,
// holds them in FIFO order, and checks each one against the EX-stage jalr target.
module ret_pred_queue #(
    parameter int DEPTH_INDEX = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   if_valid,
    input  logic [31:0]            if_rdata,
    input  logic [31:0]            ras_target,
    input  logic                   ras_empty,
    input  logic                   ex_ret_valid,
    input  logic [31:0]            ex_target,
    output logic                   pred_taken,
    output logic [31:0]            pred_target,
    output logic                   fetch_stall,
    output logic                   mispredict,
    output logic [31:0]            correct_target,
    output logic [DEPTH_INDEX:0]   count
);

    localparam int DEPTH = 2 ** DEPTH_INDEX;
    localparam logic [DEPTH_INDEX:0] FULL_COUNT = (DEPTH_INDEX + 1)'(DEPTH);

    // jalr x0, imm(x1|x5): only opcode, rd and rs1 matter, so the mask keeps just those fields
    function automatic logic is_return_f(input logic [31:0] insn);
        logic [31:0] fields;
        fields = insn & 32'h000F_8FFF;
        return (fields == 32'h0000_8067) || (fields == 32'h0002_8067);
    endfunction

    logic [DEPTH_INDEX-1:0] head_r;
    logic [DEPTH_INDEX-1:0] tail_r;
    logic [DEPTH_INDEX:0]   count_r;
    logic                   pv_mem_r  [DEPTH];
    logic [31:0]            tgt_mem_r [DEPTH];
    logic                   mispredict_r;
    logic [31:0]            correct_target_r;

    logic        is_return_s;
    logic        full_s;
    logic        empty_s;
    logic        enq_fire_s;
    logic        resolve_s;
    logic        deq_fire_s;
    logic [31:0] pred_target_s;
    logic [31:0] actual_target_s;
    logic        mispredict_next_s;

    // Fetch-side decode, fire conditions and the resolve comparison
    always_comb begin
        is_return_s       = is_return_f(if_rdata);
        full_s            = (count_r == FULL_COUNT);
        empty_s           = (count_r == {(DEPTH_INDEX + 1){1'b0}});
        enq_fire_s        = if_valid & is_return_s & ~stall & ~flush & ~full_s;
        resolve_s         = ex_ret_valid & ~stall & ~flush;
        deq_fire_s        = resolve_s & ~empty_s;
        pred_target_s     = ras_target & ~32'h0000_0001;
        actual_target_s   = ex_target & ~32'h0000_0001;
        mispredict_next_s = 1'b0;
        if (empty_s) begin
            mispredict_next_s = 1'b1;
        end else begin
            mispredict_next_s = ~pv_mem_r[head_r] | (tgt_mem_r[head_r] != actual_target_s);
        end
    end

    // Occupancy and pointers; flush and reset both empty the queue
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_r  <= {DEPTH_INDEX{1'b0}};
            tail_r  <= {DEPTH_INDEX{1'b0}};
            count_r <= {(DEPTH_INDEX + 1){1'b0}};
        end else begin
            if (enq_fire_s) begin
                tail_r <= tail_r + DEPTH_INDEX'(1);
            end
            if (deq_fire_s) begin
                head_r <= head_r + DEPTH_INDEX'(1);
            end
            case ({enq_fire_s, deq_fire_s})
                2'b10:   count_r <= count_r + (DEPTH_INDEX + 1)'(1);
                2'b01:   count_r <= count_r - (DEPTH_INDEX + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; stale contents are harmless once pointers are reset
    always_ff @(posedge clk) begin
        if (enq_fire_s) begin
            pv_mem_r[tail_r]  <= ~ras_empty;
            tgt_mem_r[tail_r] <= pred_target_s;
        end
    end

    // One-cycle mispredict pulse per resolve; correct_target holds between resolves
    always_ff @(posedge clk) begin
        if (rst) begin
            mispredict_r     <= 1'b0;
            correct_target_r <= 32'h0000_0000;
        end else if (resolve_s) begin
            mispredict_r     <= mispredict_next_s;
            correct_target_r <= actual_target_s;
        end else begin
            mispredict_r     <= 1'b0;
        end
    end

    assign pred_taken     = enq_fire_s & ~ras_empty;
    assign pred_target    = pred_target_s;
    assign fetch_stall    = if_valid & is_return_s & full_s;
    assign mispredict     = mispredict_r;
    assign correct_target = correct_target_r;
    assign count          = count_r;

endmodule

// File: tb/tb_ret_pred_queue.sv
// Bench for ret_pred_queue: directed scenarios then random traffic, all checked
// against a queue-based reference model of the predictor.
module tb_ret_pred_queue;

    localparam int DI    = 2;
    localparam int DEPTH = 4;
    localparam logic [31:0] RET1 = 32'h0000_8067;
    localparam logic [31:0] RET5 = 32'h0002_8067;

    logic        clk = 1'b0;
    logic        rst, stall, flush, if_valid, ras_empty, ex_ret_valid;
    logic [31:0] if_rdata, ras_target, ex_target;
    logic        pred_taken, fetch_stall, mispredict;
    logic [31:0] pred_target, correct_target;
    logic [DI:0] count;

    int n_assert = 0;
    int n_fail   = 0;

    logic [32:0] q[$];
    logic        exp_mp;
    logic [31:0] exp_ct;

    ret_pred_queue #(.DEPTH_INDEX(DI)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .if_valid(if_valid), .if_rdata(if_rdata),
        .ras_target(ras_target), .ras_empty(ras_empty),
        .ex_ret_valid(ex_ret_valid), .ex_target(ex_target),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .fetch_stall(fetch_stall), .mispredict(mispredict),
        .correct_target(correct_target), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive, check combinational outputs, advance model, check registered outputs.
    task automatic cycle(input logic iv, input logic [31:0] insn, input logic [31:0] rt,
                         input logic re, input logic xv, input logic [31:0] xt,
                         input logic st, input logic fl, input logic r);
        logic        ret, full, enq;
        logic [31:0] act;
        logic [32:0] h;
        if_valid = iv; if_rdata = insn; ras_target = rt; ras_empty = re;
        ex_ret_valid = xv; ex_target = xt; stall = st; flush = fl; rst = r;
        ret  = (insn[6:0] == 7'b1100111) && (insn[11:7] == 5'd0) &&
               ((insn[19:15] == 5'd1) || (insn[19:15] == 5'd5));
        full = (q.size() == DEPTH);
        enq  = iv && ret && !st && !fl && !full;
        act  = {xt[31:1], 1'b0};
        #1;
        if (!r) begin
            chk("pred_taken", {31'd0, pred_taken}, {31'd0, enq && !re});
            chk("pred_target", pred_target, {rt[31:1], 1'b0});
            chk("fetch_stall", {31'd0, fetch_stall}, {31'd0, iv && ret && full});
        end
        @(posedge clk);
        if (r) begin
            q.delete(); exp_mp = 1'b0; exp_ct = 32'h0;
        end else if (fl) begin
            q.delete(); exp_mp = 1'b0;
        end else if (st) begin
            exp_mp = 1'b0;
        end else begin
            exp_mp = 1'b0;
            if (xv) begin
                exp_ct = act;
                if (q.size() == 0) begin
                    exp_mp = 1'b1;
                end else begin
                    h = q.pop_front();
                    exp_mp = !h[32] || (h[31:0] != act);
                end
            end
            if (enq) q.push_back({!re, rt[31:1], 1'b0});
        end
        #1;
        chk("mispredict", {31'd0, mispredict}, {31'd0, exp_mp});
        chk("correct_target", correct_target, exp_ct);
        chk("count", {29'd0, count}, q.size());
    endtask

    initial begin
        logic [31:0] insn, rt, xt;
        rst = 1'b1; stall = 1'b0; flush = 1'b0; if_valid = 1'b0; if_rdata = 32'h0;
        ras_target = 32'h0; ras_empty = 1'b1; ex_ret_valid = 1'b0; ex_target = 32'h0;
        exp_mp = 1'b0; exp_ct = 32'h0;

        cycle(0, 32'h0, 32'h0, 1, 0, 32'h0, 0, 0, 1);
        // taken prediction then correct resolve
        cycle(1, RET1, 32'h0000_1235, 0, 0, 32'h0, 0, 0, 0);
        cycle(0, 32'h0, 32'h0, 0, 1, 32'h0000_1234, 0, 0, 0);
        // RAS empty: fall-through prediction, resolve mispredicts
        cycle(1, RET5, 32'h0000_4444, 1, 0, 32'h0, 0, 0, 0);
        cycle(0, 32'h0, 32'h0, 0, 1, 32'h0000_2000, 0, 0, 0);
        cycle(0, 32'h0, 32'h0, 0, 0, 32'h0, 0, 0, 0);
        // resolve with empty queue
        cycle(0, 32'h0, 32'h0, 0, 1, 32'h0000_3001, 0, 0, 0);
        // near-miss decode: rd != x0
        cycle(1, 32'h0000_80E7, 32'h0000_5000, 0, 0, 32'h0, 0, 0, 0);
        // fill to full, then fifth return stalls, also with a same-cycle resolve
        for (int i = 0; i < 4; i++) cycle(1, RET1, 32'h0000_1000 + 32'(i * 16), 0, 0, 32'h0, 0, 0, 0);
        cycle(1, RET1, 32'h0000_7777, 0, 0, 32'h0, 0, 0, 0);
        cycle(1, RET5, 32'h0000_7777, 0, 1, 32'h0000_1000, 0, 0, 0);
        // flush with 3 queued overrides resolve
        cycle(0, 32'h0, 32'h0, 0, 1, 32'h0000_1010, 0, 1, 0);
        // stall blocks enqueue and resolve
        cycle(1, RET1, 32'h0000_6000, 0, 0, 32'h0, 0, 0, 0);
        cycle(1, RET1, 32'h0000_6100, 0, 1, 32'h0000_6000, 1, 0, 0);
        // simultaneous enqueue and dequeue
        cycle(1, RET5, 32'h0000_6200, 0, 1, 32'h0000_6000, 0, 0, 0);
        // reset with 2 queued and a resolve pending
        cycle(1, RET1, 32'h0000_6300, 0, 0, 32'h0, 0, 0, 0);
        cycle(0, 32'h0, 32'h0, 0, 1, 32'h0000_6200, 0, 0, 1);

        for (int n = 0; n < 500; n++) begin
            case ($urandom_range(0, 3))
                0:       insn = RET1;
                1:       insn = RET5;
                2:       insn = {12'($urandom), 5'd1, 3'd0, 5'($urandom_range(1, 31)), 7'b1100111};
                default: insn = $urandom;
            endcase
            rt = {16'h0, 16'($urandom_range(0, 7) * 4 + 1)};
            xt = ($urandom_range(0, 3) != 0 && q.size() != 0) ? q[0][31:0] | 32'($urandom_range(0, 1))
                                                             : {16'h0, 16'($urandom_range(0, 31))};
            cycle($urandom_range(0, 9) < 7, insn, rt, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 9) < 4, xt, $urandom_range(0, 9) < 2,
                  $urandom_range(0, 29) == 0, $urandom_range(0, 99) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
